// File: rtl/spi_ram_bridge_burst.sv
// SPI slave bridged to a single-port RAM, with address auto-increment,
// gapless burst write/read inside one SS_n assertion and an abort pulse.
module spi_ram_bridge_burst #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int AUTO_INC   = 1,
    parameter int BURST_EN   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic frame_abort
);

    localparam int WW = DATA_WIDTH + 2;
    localparam int CW = $clog2(WW);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [BW-1:0]       LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam bit INC_C   = (AUTO_INC != 0);
    localparam bit BURST_C = (BURST_EN != 0);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CHK_CMD    = 3'd1,
        WRITE      = 3'd2,
        READ_ADD   = 3'd3,
        READ_DATA  = 3'd4,
        READ_SHIFT = 3'd5
    } state_t;

    state_t                  state_r;
    logic [WW-2:0]           sr_r;
    logic [CW-1:0]           cnt_r;
    logic                    first_r;
    logic                    hold_r;
    logic [WW-1:0]           word_r;
    logic                    word_vld_r;
    logic [BW-1:0]           bit_cnt_r;
    logic [ADDR_WIDTH-1:0]   wr_addr_r;
    logic [ADDR_WIDTH-1:0]   rd_addr_r;
    logic [DATA_WIDTH-1:0]   rdata_r;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic [WW-1:0]           full_s;
    logic [1:0]              word_cmd_s;
    logic [CW-1:0]           len_m1_s;
    logic                    mem_we_s;
    logic                    rd_en_s;
    logic                    abort_s;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < DEPTH_C);
    endfunction

    // Addresses that would reach MEM_DEPTH (or already lie beyond it) wrap to 0.
    function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] n;
        n = {1'b0, a} + {{ADDR_WIDTH{1'b0}}, 1'b1};
        if (n >= DEPTH_C) begin
            return {ADDR_WIDTH{1'b0}};
        end else begin
            return n[ADDR_WIDTH-1:0];
        end
    endfunction

    assign full_s     = {sr_r, MOSI};
    assign word_cmd_s = word_r[WW-1:WW-2];
    assign len_m1_s   = first_r ? CW'(WW - 1) : CW'(DATA_WIDTH - 1);
    assign mem_we_s   = word_vld_r && (state_r == WRITE) && (word_cmd_s == 2'b01) && in_range(wr_addr_r);
    assign rd_en_s    = !SS_n && ((state_r == READ_DATA) ||
                        ((state_r == READ_SHIFT) && (bit_cnt_r == LAST_BIT) && BURST_C));

    // Abort only when SS_n rises with part of a word already transferred.
    always_comb begin
        abort_s = 1'b0;
        case (state_r)
            WRITE, READ_ADD: begin
                if (!hold_r && ((cnt_r != {CW{1'b0}}) || first_r)) begin
                    abort_s = 1'b1;
                end else begin
                    abort_s = 1'b0;
                end
            end
            READ_SHIFT: begin
                if (bit_cnt_r != {BW{1'b0}}) begin
                    abort_s = 1'b1;
                end else begin
                    abort_s = 1'b0;
                end
            end
            default: abort_s = 1'b0;
        endcase
    end

    // RAM array and registered read port; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[wr_addr_r[IW-1:0]] <= word_r[DATA_WIDTH-1:0];
        end
        if (rd_en_s) begin
            rdata_r <= in_range(rd_addr_r) ? mem[rd_addr_r[IW-1:0]] : {DATA_WIDTH{1'b0}};
        end
    end

    // Frame FSM, address registers and serial output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            sr_r        <= {(WW-1){1'b0}};
            cnt_r       <= {CW{1'b0}};
            first_r     <= 1'b1;
            hold_r      <= 1'b0;
            word_r      <= {WW{1'b0}};
            word_vld_r  <= 1'b0;
            bit_cnt_r   <= {BW{1'b0}};
            wr_addr_r   <= {ADDR_WIDTH{1'b0}};
            rd_addr_r   <= {ADDR_WIDTH{1'b0}};
            MISO        <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            MISO        <= 1'b0;
            frame_abort <= 1'b0;
            word_vld_r  <= 1'b0;

            // A completed word is committed even if SS_n rises on this edge.
            if (word_vld_r && (state_r == WRITE)) begin
                if (word_cmd_s == 2'b00) begin
                    wr_addr_r <= word_r[ADDR_WIDTH-1:0];
                end else if ((word_cmd_s == 2'b01) && INC_C) begin
                    wr_addr_r <= addr_inc(wr_addr_r);
                end
            end
            if (word_vld_r && (state_r == READ_ADD) && (word_cmd_s == 2'b10)) begin
                rd_addr_r <= word_r[ADDR_WIDTH-1:0];
            end
            if (rd_en_s && INC_C) begin
                rd_addr_r <= addr_inc(rd_addr_r);
            end

            if (SS_n && (state_r != IDLE)) begin
                state_r     <= IDLE;
                frame_abort <= abort_s;
                cnt_r       <= {CW{1'b0}};
                bit_cnt_r   <= {BW{1'b0}};
                first_r     <= 1'b1;
                hold_r      <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (!SS_n) begin
                            state_r <= CHK_CMD;
                            cnt_r   <= {CW{1'b0}};
                            first_r <= 1'b1;
                            hold_r  <= 1'b0;
                        end
                    end
                    CHK_CMD: state_r <= MOSI ? READ_ADD : WRITE;
                    WRITE, READ_ADD: begin
                        if (word_vld_r && (state_r == READ_ADD) && (word_cmd_s == 2'b11)) begin
                            state_r <= READ_DATA;
                        end else if (!hold_r) begin
                            sr_r <= full_s[WW-2:0];
                            if (cnt_r == len_m1_s) begin
                                cnt_r      <= {CW{1'b0}};
                                word_vld_r <= 1'b1;
                                // Burst data words carry no prefix; tag them as writes.
                                word_r     <= first_r ? full_s : {2'b01, full_s[DATA_WIDTH-1:0]};
                                if ((state_r == WRITE) && BURST_C &&
                                    (!first_r || (full_s[WW-1:WW-2] == 2'b01))) begin
                                    first_r <= 1'b0;
                                end else begin
                                    hold_r <= 1'b1;
                                end
                            end else begin
                                cnt_r <= cnt_r + CW'(1);
                            end
                        end
                    end
                    READ_DATA: begin
                        state_r   <= READ_SHIFT;
                        bit_cnt_r <= {BW{1'b0}};
                    end
                    READ_SHIFT: begin
                        MISO <= rdata_r[LAST_BIT - bit_cnt_r];
                        if (bit_cnt_r == LAST_BIT) begin
                            bit_cnt_r <= {BW{1'b0}};
                            if (!BURST_C) begin
                                state_r <= READ_ADD;
                                hold_r  <= 1'b1;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BW'(1);
                        end
                    end
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_bridge_burst.sv
// Drives two bridges (depth 256 and depth 200) with identical SPI frames and
// checks both against a frame-level memory model every cycle.
module tb_spi_ram_bridge_burst;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ss_n = 1'b1;
    logic mosi = 1'b0;
    logic miso_a, abort_a, miso_b, abort_b;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q [$];
    logic       obs_a, obs_b;
    logic [7:0] rx_a [4];
    logic [7:0] rx_b [4];

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;

    always #5 clk = ~clk;

    spi_ram_bridge_burst #(.MEM_DEPTH(256)) dut_a (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .MOSI(mosi),
        .MISO(miso_a), .frame_abort(abort_a)
    );

    spi_ram_bridge_burst #(.MEM_DEPTH(200)) dut_b (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .MOSI(mosi),
        .MISO(miso_b), .frame_abort(abort_b)
    );

    function automatic int nxt(input int a, input int depth);
        return (a + 1 >= depth) ? 0 : a + 1;
    endfunction

    // Per-cycle comparison of both instances against the queued expectations.
    always @(posedge clk) begin
        logic [3:0] e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({miso_a, abort_a} !== e[3:2]) begin
                errors++;
                $display("FAIL cycle_a t=%0t miso/abort got %b%b expected %b", $time, miso_a, abort_a, e[3:2]);
            end
            checks++;
            if ({miso_b, abort_b} !== e[1:0]) begin
                errors++;
                $display("FAIL cycle_b t=%0t miso/abort got %b%b expected %b", $time, miso_b, abort_b, e[1:0]);
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    task automatic step(input logic ss, input logic mo, input logic [3:0] e);
        @(negedge clk);
        ss_n = ss;
        mosi = mo;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        obs_a = miso_a;
        obs_b = miso_b;
    endtask

    task automatic start_frame(input logic path);
        step(1'b0, 1'b0, 4'b0000);
        step(1'b0, path, 4'b0000);
    endtask

    task automatic send_bits(input logic [9:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b0, v[i], 4'b0000);
    endtask

    task automatic end_frame(input logic ab);
        step(1'b1, 1'b0, {1'b0, ab, 1'b0, ab});
        step(1'b1, 1'b0, 4'b0000);
    endtask

    task automatic wr_cmd(input logic [1:0] cmd, input logic [7:0] pay);
        start_frame(1'b0);
        send_bits({cmd, pay}, 10);
        end_frame(1'b0);
        if (cmd == 2'b00) begin
            wr_a = int'(pay);
            wr_b = int'(pay);
        end else begin
            if (wr_a < 256) mem_a[wr_a] = pay;
            if (wr_b < 200) mem_b[wr_b] = pay;
            wr_a = nxt(wr_a, 256);
            wr_b = nxt(wr_b, 200);
        end
    endtask

    task automatic wr_burst(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
        logic [7:0] w [3];
        w[0] = w0; w[1] = w1; w[2] = w2;
        start_frame(1'b0);
        send_bits({2'b01, w0}, 10);
        send_bits({2'b00, w1}, 8);
        send_bits({2'b00, w2}, 8);
        end_frame(1'b0);
        for (int k = 0; k < 3; k++) begin
            if (wr_a < 256) mem_a[wr_a] = w[k];
            if (wr_b < 200) mem_b[wr_b] = w[k];
            wr_a = nxt(wr_a, 256);
            wr_b = nxt(wr_b, 200);
        end
    endtask

    task automatic rd_set(input logic [7:0] addr);
        start_frame(1'b1);
        send_bits({2'b10, addr}, 10);
        end_frame(1'b0);
        rd_a = int'(addr);
        rd_b = int'(addr);
    endtask

    task automatic rd_data(input int nbits, input bit do_reset);
        logic [7:0] wa, wb;
        wa = 8'h00;
        wb = 8'h00;
        for (int k = 0; k < 4; k++) begin
            rx_a[k] = 8'h00;
            rx_b[k] = 8'h00;
        end
        start_frame(1'b1);
        send_bits({2'b11, 8'h5A}, 10);
        step(1'b0, 1'b1, 4'b0000);
        step(1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < nbits; i++) begin
            if (i % 8 == 0) begin
                wa = (rd_a < 256) ? mem_a[rd_a] : 8'h00;
                wb = (rd_b < 200) ? mem_b[rd_b] : 8'h00;
                rd_a = nxt(rd_a, 256);
                rd_b = nxt(rd_b, 200);
            end
            step(1'b0, 1'($urandom_range(0, 1)), {wa[7 - i % 8], 1'b0, wb[7 - i % 8], 1'b0});
            rx_a[i / 8] = {rx_a[i / 8][6:0], obs_a};
            rx_b[i / 8] = {rx_b[i / 8][6:0], obs_b};
        end
        if (do_reset) begin
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("reset_miso_a", {7'b0, miso_a}, 8'h00);
            check("reset_miso_b", {7'b0, miso_b}, 8'h00);
            step(1'b1, 1'b0, 4'b0000);
            step(1'b1, 1'b0, 4'b0000);
            rst_n = 1'b1;
            step(1'b1, 1'b0, 4'b0000);
            wr_a = 0; rd_a = 0; wr_b = 0; rd_b = 0;
        end else begin
            // Ending on a word boundary leaves one prefetch already done.
            if (nbits % 8 == 0) begin
                rd_a = nxt(rd_a, 256);
                rd_b = nxt(rd_b, 200);
            end
            end_frame(nbits % 8 != 0);
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            mem_a[k] = 8'h00;
            mem_b[k] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_miso_a", {7'b0, miso_a}, 8'h00);
        check("rst_abort_a", {7'b0, abort_a}, 8'h00);
        check("rst_miso_b", {7'b0, miso_b}, 8'h00);
        check("rst_abort_b", {7'b0, abort_b}, 8'h00);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 4'b0000);

        // Basic write then read.
        wr_cmd(2'b00, 8'h12);
        wr_cmd(2'b01, 8'hA5);
        rd_set(8'h12);
        rd_data(8, 1'b0);
        check("basic_a", rx_a[0], 8'hA5);
        check("basic_b", rx_b[0], 8'hA5);

        // Burst write wrapping past the top of each memory, then burst read.
        wr_cmd(2'b00, 8'hFE);
        wr_burst(8'h11, 8'h22, 8'h33);
        rd_set(8'hFE);
        rd_data(24, 1'b0);
        check("burst_a0", rx_a[0], 8'h11);
        check("burst_a1", rx_a[1], 8'h22);
        check("burst_a2", rx_a[2], 8'h33);
        check("burst_b0", rx_b[0], 8'h00);
        check("burst_b1", rx_b[1], 8'h22);
        check("burst_b2", rx_b[2], 8'h33);

        // Aborted write leaves address and RAM alone.
        wr_cmd(2'b00, 8'h40);
        start_frame(1'b0);
        send_bits({3'b000, 2'b01, 5'b10110}, 7);
        end_frame(1'b1);
        wr_cmd(2'b01, 8'h77);
        rd_set(8'h40);
        rd_data(8, 1'b0);
        check("after_abort_a", rx_a[0], 8'h77);
        rd_set(8'h40);
        rd_data(3, 1'b0);

        // Out-of-range address on the 200-deep instance.
        wr_cmd(2'b00, 8'hC8);
        wr_cmd(2'b01, 8'h5C);
        rd_set(8'hC8);
        rd_data(8, 1'b0);
        check("oor_a", rx_a[0], 8'h5C);
        check("oor_b", rx_b[0], 8'h00);
        wr_cmd(2'b00, 8'hC7);
        wr_cmd(2'b01, 8'h9E);
        rd_set(8'hC7);
        rd_data(16, 1'b0);
        check("edge_a0", rx_a[0], 8'h9E);
        check("edge_a1", rx_a[1], 8'h5C);
        check("edge_b0", rx_b[0], 8'h9E);
        check("edge_b1", rx_b[1], 8'h22);

        // Asynchronous reset in the middle of a shift-out, then read from 0.
        rd_set(8'h12);
        rd_data(3, 1'b1);
        rd_data(8, 1'b0);
        check("post_reset_a", rx_a[0], 8'h33);
        check("post_reset_b", rx_b[0], 8'h22);

        repeat (3) @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_ram_bridge_burst.md
Name: spi_ram_bridge_burst

Overview:
- SPI slave and single-port RAM in one block, bridging an external SPI master to on-chip memory.
- Successor of the fixed 8-bit/256-word SPI-RAM wrapper. Data width, address width and depth are parametrised.
- Adds address auto-increment, burst write/read within one SS_n assertion, out-of-range address handling and an abort indication.
- Sits at chip top, directly on the SPI pins.

Parameters:
- DATA_WIDTH, 8: RAM word width and SPI payload width. ADDR_WIDTH <= DATA_WIDTH is required.
- ADDR_WIDTH, 8: address register width.
- MEM_DEPTH, 256: number of words, <= 2**ADDR_WIDTH.
- AUTO_INC, 1: 1 means the write/read address post-increments after each data word.
- BURST_EN, 1: 1 means further data words are accepted or produced while SS_n stays low. Requires AUTO_INC=1.

Ports:
- clk  in  1  system clock; also the SPI bit clock. MOSI is sampled and MISO is updated on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- SS_n  in  1  slave select, active-low.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first.
- frame_abort  out  1  one-cycle pulse when SS_n rises mid-frame.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to IDLE; MISO=0; frame_abort=0.
  - wr_addr=0, rd_addr=0; shift counters=0.
  - RAM contents are not reset.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, READ_SHIFT.
- IDLE: SS_n=0 moves to CHK_CMD on the next edge.
- CHK_CMD: samples the first MOSI bit. 0 goes to WRITE; 1 goes to READ_ADD.
- WRITE / READ_ADD shift in 2+DATA_WIDTH bits: cmd[1:0], then payload. The command is decoded one cycle after the last bit is sampled (cycle T):
  - 00: wr_addr <= payload[ADDR_WIDTH-1:0].
  - 01: mem[wr_addr] <= payload; wr_addr increments if AUTO_INC.
  - 10: rd_addr <= payload[ADDR_WIDTH-1:0].
  - 11: go to READ_DATA. The dummy payload is ignored.
- Cmd on the wrong path (write-path cmd 1x, read-path cmd 0x): frame is ignored and the FSM waits in place for SS_n=1.
- READ_DATA:
  - RAM output is registered at T+1.
  - MISO drives bit DATA_WIDTH-1 at T+2, then one bit per cycle (READ_SHIFT).
  - rd_addr increments on each fetch if AUTO_INC.
- Burst write (BURST_EN=1): after a 01 word, if SS_n stays low, each further DATA_WIDTH bits (no cmd prefix) is one more write to the incremented address.
- Burst read (BURST_EN=1):
  - The next word is prefetched during the shift-out of the current word.
  - Its MSB follows the previous LSB on the very next cycle, with no gap.
  - MOSI is ignored in this mode.
- BURST_EN=0: after one word the FSM idles until SS_n=1.
- Wrap-around: an address that would reach MEM_DEPTH becomes 0.
- Out-of-range addresses (>= MEM_DEPTH, reachable only via cmd 00/10):
  - Writes are dropped.
  - Reads return all-zero.
  - Increment still applies.
- SS_n=1 in any state other than IDLE:
  - Next state is IDLE; MISO goes to 0 on the next edge.
  - A partially received word is discarded: no RAM write, no address change.
  - frame_abort pulses one cycle if at least one bit of the current word was received or sent.
- Word-boundary end: SS_n rising exactly after a complete word is a normal end; frame_abort is not pulsed.
- MISO=0 in all states except READ_SHIFT.
- Simultaneous events: a write and a prefetch read never coincide. Each frame is write-only or read-only.

Test Plan:
- Basic write/read: write frames 0-00-0x12, then 0-01-0xA5; read frames 1-10-0x12, then 1-11-dummy -> MISO = 1010_0101 starting at T+2.
- Burst write with wrap: 0-00-0xFE; then one SS_n-low frame 0-01-0x11, 0x22, 0x33 -> mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33, wr_addr=0x01.
- Burst read: 1-10-0xFE; then 1-11-dummy held for 24 shift cycles -> MISO bytes 0x11, 0x22, 0x33 with no gap cycles.
- Abort: SS_n raised after 5 payload bits of a 0-01 frame -> frame_abort pulses once, RAM and wr_addr unchanged; the next frame behaves normally.
- Async reset mid read-shift: rst_n=0 at bit 3 -> MISO=0 immediately; after release, rd_addr=0 and the FSM is in IDLE.
- MEM_DEPTH=200: write to 0xC8 is dropped; a read of 0xC8 returns 0x00; a burst from 0xC7 wraps to 0x00.
